// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI4-Lite register-bank responder with flat register export
// Build option: AXIL_SLV_DECERR_EN makes out-of-range accesses answer DECERR; otherwise every response is OKAY.
module axil_reg_slave #(
  parameter int AW   = 12,
  parameter int DW   = 32,
  parameter int NREG = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        s_awaddr,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [DW-1:0]        s_wdata,
  input  logic [DW/8-1:0]      s_wstrb,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  output logic [1:0]           s_bresp,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  input  logic [AW-1:0]        s_araddr,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  output logic [DW-1:0]        s_rdata,
  output logic [1:0]           s_rresp,
  output logic                 s_rvalid,
  input  logic                 s_rready,
  output logic [NREG*DW-1:0]   reg_q
);

  localparam int OFS = $clog2(DW/8);
  localparam int IW  = $clog2(NREG);
  localparam int NB  = DW/8;
  // First byte address past the register bank.
  localparam logic [AW-1:0] LIMIT = AW'(NREG*DW/8);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] RESP_OOR = 2'b11;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  logic [DW-1:0]   r_regs [NREG];
  logic            r_aw_full;
  logic [AW-1:0]   r_awaddr;
  logic            r_w_full;
  logic [DW-1:0]   r_wdata;
  logic [NB-1:0]   r_wstrb;
  logic            r_bvalid;
  logic [1:0]      r_bresp;
  logic            r_rvalid;
  logic [DW-1:0]   r_rdata;
  logic [1:0]      r_rresp;

  logic            w_commit;
  logic            w_wr_oor;
  logic [IW-1:0]   w_wr_idx;
  logic            w_rd_oor;
  logic [IW-1:0]   w_rd_idx;
  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_ar_hs;

  // Readies depend only on registered state, so there is no valid-to-ready path.
  assign s_awready = !r_aw_full && !r_bvalid;
  assign s_wready  = !r_w_full && !r_bvalid;
  assign s_arready = !r_rvalid;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = r_rresp;

  assign w_aw_hs  = s_awvalid && s_awready;
  assign w_w_hs   = s_wvalid && s_wready;
  assign w_ar_hs  = s_arvalid && s_arready;
  assign w_commit = r_aw_full && r_w_full && !r_bvalid;

  assign w_wr_oor = (r_awaddr >= LIMIT);
  assign w_wr_idx = r_awaddr[OFS +: IW];
  assign w_rd_oor = (s_araddr >= LIMIT);
  assign w_rd_idx = s_araddr[OFS +: IW];

  // One-deep AW and W holds, filled independently and drained together on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_full <= 1'b0;
      r_awaddr  <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_awaddr  <= s_awaddr;
      end else if (w_commit) begin
        r_aw_full <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_wdata;
        r_wstrb  <= s_wstrb;
      end else if (w_commit) begin
        r_w_full <= 1'b0;
      end
    end
  end

  // Write response: raised on commit, held until the master takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_oor ? RESP_OOR : RESP_OKAY;
    end else if (r_bvalid && s_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Register bank with per-byte strobe merge; out-of-range writes touch nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit && !w_wr_oor) begin
      for (int b = 0; b < NB; b++) begin
        if (r_wstrb[b]) begin
          r_regs[w_wr_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read channel: capture on AR handshake (pre-commit value), hold until R handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_oor ? '0 : r_regs[w_rd_idx];
      r_rresp  <= w_rd_oor ? RESP_OOR : RESP_OKAY;
    end else if (r_rvalid && s_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_flat
      assign reg_q[gi*DW +: DW] = r_regs[gi];
    end
  endgenerate

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb/tb_axil_reg_slave.sv - directed self-checking bench for axil_reg_slave
module tb_axil_reg_slave;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int NREG = 16;
`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] EXP_OOR = 2'b11;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [AW-1:0]        s_awaddr;
  logic                 s_awvalid;
  logic                 s_awready;
  logic [DW-1:0]        s_wdata;
  logic [DW/8-1:0]      s_wstrb;
  logic                 s_wvalid;
  logic                 s_wready;
  logic [1:0]           s_bresp;
  logic                 s_bvalid;
  logic                 s_bready;
  logic [AW-1:0]        s_araddr;
  logic                 s_arvalid;
  logic                 s_arready;
  logic [DW-1:0]        s_rdata;
  logic [1:0]           s_rresp;
  logic                 s_rvalid;
  logic                 s_rready;
  logic [NREG*DW-1:0]   reg_q;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_regs [NREG];

  axil_reg_slave #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .reg_q(reg_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREG; i++) begin
      check($sformatf("%s_reg%0d", tag, i), 64'(reg_q[i*DW +: DW]), 64'(exp_regs[i]));
    end
  endtask

  // AW and W presented together with bready=1; checks latency and response.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp, input string tag);
    s_awaddr = addr; s_awvalid = 1'b1;
    s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
    s_bready = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check({tag, "_bvalid_hs"}, 64'(s_bvalid), 64'd0);
    check({tag, "_awready_full"}, 64'(s_awready), 64'd0);
    tick();
    check({tag, "_bvalid"}, 64'(s_bvalid), 64'd1);
    check({tag, "_bresp"}, 64'(s_bresp), 64'(exp_resp));
    tick();
    check({tag, "_bvalid_clr"}, 64'(s_bvalid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    for (int i = 0; i < NREG; i++) exp_regs[i] = '0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_bvalid", 64'(s_bvalid), 64'd0);
    check("rst_rvalid", 64'(s_rvalid), 64'd0);
    check("rst_awready", 64'(s_awready), 64'd1);
    check("rst_wready", 64'(s_wready), 64'd1);
    check("rst_arready", 64'(s_arready), 64'd1);
    check("rst_rdata", 64'(s_rdata), 64'd0);
    check_regs("rst");

    // AW+W same cycle
    do_write(12'h004, 32'hDEADBEEF, 4'hF, 2'b00, "wr1");
    exp_regs[1] = 32'hDEADBEEF;
    check("wr1_regq", 64'(reg_q[63:32]), 64'hDEADBEEF);

    // W three cycles ahead of AW
    s_wdata = 32'h11223344; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("wfirst_wready%0d", k), 64'(s_wready), 64'd0);
      check($sformatf("wfirst_awready%0d", k), 64'(s_awready), 64'd1);
      check($sformatf("wfirst_bvalid%0d", k), 64'(s_bvalid), 64'd0);
      if (k < 2) tick();
    end
    s_awaddr = 12'h008; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    check("wfirst_bvalid_hs", 64'(s_bvalid), 64'd0);
    tick();
    check("wfirst_bvalid", 64'(s_bvalid), 64'd1);
    exp_regs[2] = 32'h11223344;
    check_regs("wfirst");
    tick();

    // byte-strobe merge
    do_write(12'h00C, 32'hFFFFFFFF, 4'hF, 2'b00, "strb_a");
    do_write(12'h00C, 32'h000000AB, 4'b0001, 2'b00, "strb_b");
    exp_regs[3] = 32'hFFFFFFAB;
    check("strb_reg3", 64'(reg_q[127:96]), 64'hFFFFFFAB);

    // read with rready low for 4 cycles
    s_araddr = 12'h004; s_arvalid = 1'b1; s_rready = 1'b0;
    tick();
    s_arvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rd_rvalid%0d", k), 64'(s_rvalid), 64'd1);
      check($sformatf("rd_rdata%0d", k), 64'(s_rdata), 64'hDEADBEEF);
      check($sformatf("rd_arready%0d", k), 64'(s_arready), 64'd0);
      if (k < 3) tick();
    end
    check("rd_rresp", 64'(s_rresp), 64'd0);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    check("rd_rvalid_clr", 64'(s_rvalid), 64'd0);
    check("rd_arready_back", 64'(s_arready), 64'd1);

    // bready held low: back-pressure on AW/W
    s_bready = 1'b0;
    s_awaddr = 12'h010; s_awvalid = 1'b1;
    s_wdata = 32'h00000055; s_wstrb = 4'hF; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    tick();
    check("bp_bvalid", 64'(s_bvalid), 64'd1);
    s_awaddr = 12'h014; s_awvalid = 1'b1;
    s_wdata = 32'h00000066; s_wvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_awready%0d", k), 64'(s_awready), 64'd0);
      check($sformatf("bp_wready%0d", k), 64'(s_wready), 64'd0);
      check($sformatf("bp_bhold%0d", k), 64'(s_bvalid), 64'd1);
      tick();
    end
    s_bready = 1'b1;
    tick();
    check("bp_bvalid_clr", 64'(s_bvalid), 64'd0);
    check("bp_awready_back", 64'(s_awready), 64'd1);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("bp_awready_taken", 64'(s_awready), 64'd0);
    tick();
    check("bp_bvalid2", 64'(s_bvalid), 64'd1);
    exp_regs[4] = 32'h00000055;
    exp_regs[5] = 32'h00000066;
    check_regs("bp");
    tick();

    // out-of-range write and read
    do_write(12'h040, 32'h12345678, 4'hF, EXP_OOR, "oor_wr");
    check_regs("oor");
    s_araddr = 12'h040; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    check("oor_rvalid", 64'(s_rvalid), 64'd1);
    check("oor_rdata", 64'(s_rdata), 64'd0);
    check("oor_rresp", 64'(s_rresp), 64'(EXP_OOR));
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;

    // commit and AR to the same register on the same edge: read sees old value
    s_awaddr = 12'h004; s_awvalid = 1'b1;
    s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
    s_bready = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_araddr = 12'h004; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    check("same_bvalid", 64'(s_bvalid), 64'd1);
    check("same_rvalid", 64'(s_rvalid), 64'd1);
    check("same_rdata_old", 64'(s_rdata), 64'hDEADBEEF);
    exp_regs[1] = 32'hCAFEF00D;
    check_regs("same");
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    check("same_rvalid_clr", 64'(s_rvalid), 64'd0);
    check("same_bvalid_clr", 64'(s_bvalid), 64'd0);

    // reset with AW held and R pending
    s_awaddr = 12'h008; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    check("mid_awready", 64'(s_awready), 64'd0);
    s_araddr = 12'h008; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    check("mid_rvalid", 64'(s_rvalid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_bvalid", 64'(s_bvalid), 64'd0);
    check("mid_rvalid_clr", 64'(s_rvalid), 64'd0);
    check("mid_awready_back", 64'(s_awready), 64'd1);
    check("mid_wready", 64'(s_wready), 64'd1);
    check("mid_arready", 64'(s_arready), 64'd1);
    for (int i = 0; i < NREG; i++) exp_regs[i] = '0;
    check_regs("mid");
    tick();
    check("post_bvalid", 64'(s_bvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
